// File: rtl/rc5_pkg.sv
// Shared constants, FSM state type and 16-bit rotate helpers for the RC5-16/r/16 block.
// Purely declarative; no latency and no backpressure of its own.
package rc5_pkg;

  localparam int W          = 16;
  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;
  localparam int MAX_ROUNDS = 31;
  localparam int T_MAX      = 64;
  localparam int RW         = $clog2(MAX_ROUNDS + 1);

  typedef enum logic [2:0] {IDLE, INIT, MIX, ENC, DEC, DONE} state_t;

  // Rotating a doubled word lets a plain shift do the wrap-around.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [3:0] n);
    logic [2*W-1:0] w_tmp;
    w_tmp = {x, x} << n;
    return w_tmp[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [3:0] n);
    logic [2*W-1:0] w_tmp;
    w_tmp = {x, x} >> n;
    return w_tmp[W-1:0];
  endfunction

endpackage

// File: rtl/rc5_key_sched.sv
// Key expansion: builds S (t cycles) then mixes S/L (3*max(t,8) cycles); S read as a word pair.
// o_ready marks the last mix cycle; i_start is only honoured while idle (no backpressure).
module rc5_key_sched
  import rc5_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [RW-1:0]   i_num_rounds,
  input  logic [127:0]    i_key,
  input  logic [RW-1:0]   i_rd_idx,
  output logic            o_init_last,
  output logic            o_ready,
  output logic [W-1:0]    o_s_even,
  output logic [W-1:0]    o_s_odd
);

  state_t       r_state;
  logic [W-1:0] r_s [T_MAX];
  logic [W-1:0] r_l [8];
  logic [6:0]   r_t;
  logic [7:0]   r_cnt;
  logic [7:0]   r_mix_len;
  logic [5:0]   r_i;
  logic [2:0]   r_j;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_sval;

  logic [6:0]   w_t;
  logic [6:0]   w_t_m1;
  logic [7:0]   w_mix_len;
  logic [W-1:0] w_a_new;
  logic [W-1:0] w_ab2;
  logic [W-1:0] w_b_new;

  assign w_t       = {1'b0, i_num_rounds, 1'b0} + 7'd2;
  assign w_mix_len = (w_t < 7'd8) ? 8'd24 : ({1'b0, w_t} + {w_t, 1'b0});
  assign w_t_m1    = r_t - 7'd1;

  assign w_a_new = rotl(r_s[r_i] + r_a + r_b, 4'd3);
  assign w_ab2   = w_a_new + r_b;
  assign w_b_new = rotl(r_l[r_j] + w_ab2, w_ab2[3:0]);

  assign o_init_last = (r_state == INIT) && (r_cnt == {1'b0, w_t_m1});
  assign o_ready     = (r_state == MIX) && (r_cnt == r_mix_len - 8'd1);
  assign o_s_even    = r_s[{i_rd_idx, 1'b0}];
  assign o_s_odd     = r_s[{i_rd_idx, 1'b1}];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_t       <= '0;
      r_cnt     <= '0;
      r_mix_len <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sval    <= '0;
      for (int k = 0; k < T_MAX; k++) r_s[k] <= '0;
      for (int k = 0; k < 8; k++)     r_l[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state   <= INIT;
            r_t       <= w_t;
            r_mix_len <= w_mix_len;
            r_cnt     <= '0;
            r_sval    <= P16;
            for (int k = 0; k < 8; k++) r_l[k] <= i_key[16*k +: 16];
          end
        end
        INIT: begin
          r_s[r_cnt[5:0]] <= r_sval;
          r_sval          <= r_sval + Q16;
          if (o_init_last) begin
            r_state <= MIX;
            r_cnt   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_a     <= '0;
            r_b     <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        MIX: begin
          // A' and B' are written back into S[i] and L[j] as well as carried forward.
          r_s[r_i] <= w_a_new;
          r_l[r_j] <= w_b_new;
          r_a      <= w_a_new;
          r_b      <= w_b_new;
          r_i      <= ({1'b0, r_i} == w_t_m1) ? 6'd0 : r_i + 6'd1;
          r_j      <= r_j + 3'd1;
          if (o_ready) r_state <= IDLE;
          else         r_cnt   <= r_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rc5_algo.sv
// RC5-16/r/16 encrypt/decrypt engine; done pulses t + 3*max(t,8) + r + 2 cycles after a start.
// Starts are dropped while busy (no backpressure); d_out holds until the next completion or reset.
module rc5_algo
  import rc5_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            encrypt,
  input  logic            decrypt,
  input  logic [RW-1:0]   num_rounds,
  input  logic [127:0]    key,
  input  logic [31:0]     d_in,
  output logic [31:0]     d_out,
  output logic            done
);

  state_t        r_state;
  logic          r_mode_enc;
  logic [RW-1:0] r_nr;
  logic [RW-1:0] r_round;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;

  logic          w_start;
  logic          w_ks_init_last;
  logic          w_ks_ready;
  logic [W-1:0]  w_s_even;
  logic [W-1:0]  w_s_odd;
  logic [W-1:0]  w_enc_a;
  logic [W-1:0]  w_enc_b;
  logic [W-1:0]  w_dec_a;
  logic [W-1:0]  w_dec_b;

  assign w_start = (r_state == IDLE) && (encrypt || decrypt);

  rc5_key_sched u_key_sched (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_num_rounds (num_rounds),
    .i_key        (key),
    .i_rd_idx     (r_round),
    .o_init_last  (w_ks_init_last),
    .o_ready      (w_ks_ready),
    .o_s_even     (w_s_even),
    .o_s_odd      (w_s_odd)
  );

  // Second half of each round uses the freshly computed first half.
  assign w_enc_a = rotl(r_a ^ r_b, r_b[3:0]) + w_s_even;
  assign w_enc_b = rotl(r_b ^ w_enc_a, w_enc_a[3:0]) + w_s_odd;
  assign w_dec_b = rotr(r_b - w_s_odd, r_a[3:0]) ^ r_a;
  assign w_dec_a = rotr(r_a - w_s_even, w_dec_b[3:0]) ^ w_dec_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mode_enc <= 1'b0;
      r_nr       <= '0;
      r_round    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      d_out      <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= INIT;
            r_mode_enc <= encrypt;
            r_nr       <= num_rounds;
            r_a        <= d_in[15:0];
            r_b        <= d_in[31:16];
          end
        end
        INIT: if (w_ks_init_last) r_state <= MIX;
        MIX: begin
          if (w_ks_ready) begin
            r_state <= r_mode_enc ? ENC : DEC;
            r_round <= r_mode_enc ? '0 : r_nr;
          end
        end
        ENC: begin
          // Round index 0 is the whitening step.
          if (r_round == '0) begin
            r_a <= r_a + w_s_even;
            r_b <= r_b + w_s_odd;
          end else begin
            r_a <= w_enc_a;
            r_b <= w_enc_b;
          end
          if (r_round == r_nr) r_state <= DONE;
          else                 r_round <= r_round + 1'b1;
        end
        DEC: begin
          if (r_round == '0) begin
            r_a     <= r_a - w_s_even;
            r_b     <= r_b - w_s_odd;
            r_state <= DONE;
          end else begin
            r_a     <= w_dec_a;
            r_b     <= w_dec_b;
            r_round <= r_round - 1'b1;
          end
        end
        DONE: begin
          d_out   <= {r_b, r_a};
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_algo.sv
// Directed bench for rc5_algo: latency, known-answer via a behavioural RC5 model, round trips,
// start arbitration, busy-start rejection, mid-operation reset and output hold behaviour.
module tb_rc5_algo;

  localparam logic [127:0] KEY_SEQ = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  logic         clk;
  logic         rst;
  logic         encrypt;
  logic         decrypt;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic [31:0]  d_in;
  logic [31:0]  d_out;
  logic         done;

  int n_tests;
  int n_fail;

  rc5_algo dut (
    .clk        (clk),
    .rst        (rst),
    .encrypt    (encrypt),
    .decrypt    (decrypt),
    .num_rounds (num_rounds),
    .key        (key),
    .d_in       (d_in),
    .d_out      (d_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rl(input logic [15:0] x, input logic [15:0] n);
    int s;
    s = int'(n[3:0]);
    if (s == 0) return x;
    return (x << s) | (x >> (16 - s));
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] x, input logic [15:0] n);
    int s;
    s = int'(n[3:0]);
    if (s == 0) return x;
    return (x >> s) | (x << (16 - s));
  endfunction

  function automatic int exp_lat(input int r);
    int t;
    t = 2 * (r + 1);
    return t + 3 * ((t > 8) ? t : 8) + r + 2;
  endfunction

  // Behavioural RC5-16/r/16 reference.
  function automatic logic [31:0] ref_rc5(input logic [127:0] k, input int r,
                                          input logic [31:0] din, input bit enc);
    logic [15:0] s_tab [64];
    logic [15:0] l_tab [8];
    logic [15:0] a, b, x, y;
    int t, nmix, ii, jj;
    t = 2 * (r + 1);
    for (int q = 0; q < 64; q++) s_tab[q] = 16'h0;
    for (int q = 0; q < 8; q++) l_tab[q] = k[16*q +: 16];
    s_tab[0] = 16'hB7E1;
    for (int q = 1; q < t; q++) s_tab[q] = s_tab[q-1] + 16'h9E37;
    x = 16'h0; y = 16'h0; ii = 0; jj = 0;
    nmix = 3 * ((t > 8) ? t : 8);
    for (int q = 0; q < nmix; q++) begin
      x = rl(s_tab[ii] + x + y, 16'd3);
      s_tab[ii] = x;
      y = rl(l_tab[jj] + x + y, x + y);
      l_tab[jj] = y;
      ii = (ii + 1) % t;
      jj = (jj + 1) % 8;
    end
    a = din[15:0];
    b = din[31:16];
    if (enc) begin
      a = a + s_tab[0];
      b = b + s_tab[1];
      for (int q = 1; q <= r; q++) begin
        a = rl(a ^ b, b) + s_tab[2*q];
        b = rl(b ^ a, a) + s_tab[2*q+1];
      end
    end else begin
      for (int q = r; q >= 1; q--) begin
        b = rr(b - s_tab[2*q+1], a) ^ a;
        a = rr(a - s_tab[2*q], b) ^ b;
      end
      b = b - s_tab[1];
      a = a - s_tab[0];
    end
    return {b, a};
  endfunction

  // Caller sits #1 after a rising edge; the next edge is the start edge.
  task automatic run_op(input bit enc, input bit dec, input logic [127:0] k, input logic [4:0] r,
                        input logic [31:0] din, output int lat, output logic [31:0] res);
    bit seen;
    encrypt = enc; decrypt = dec; key = k; num_rounds = r; d_in = din;
    @(posedge clk); #1;
    encrypt = 1'b0; decrypt = 1'b0;
    lat = -1; res = 32'h0; seen = 1'b0;
    for (int n = 1; n <= 400 && !seen; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; res = d_out; seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; encrypt = 1'b1; decrypt = 1'b0;
    key = KEY_SEQ; num_rounds = 5'd12; d_in = 32'hA5A5_5A5A;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_tests++;
    if (d_out !== 32'h0) begin n_fail++; $display("FAIL reset_dout got=%h want=00000000", d_out); end
    rst = 1'b0; encrypt = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL reset_start_ignored got done=1 want no done"); end
  endtask

  task automatic test_zero_key();
    int lat;
    logic [31:0] ct, pt;
    run_op(1'b1, 1'b0, 128'h0, 5'd12, 32'hECEBECEB, lat, ct);
    n_tests++;
    if (lat !== 118) begin n_fail++; $display("FAIL zk_enc_latency got=%0d want=118", lat); end
    n_tests++;
    if (ct !== ref_rc5(128'h0, 12, 32'hECEBECEB, 1'b1)) begin
      n_fail++; $display("FAIL zk_enc_value got=%h want=%h", ct, ref_rc5(128'h0, 12, 32'hECEBECEB, 1'b1));
    end
    n_tests++;
    if (ct === 32'hECEBECEB) begin n_fail++; $display("FAIL zk_ct_differs got=%h want!=ecebeceb", ct); end
    run_op(1'b0, 1'b1, 128'h0, 5'd12, ct, lat, pt);
    n_tests++;
    if (lat !== 118) begin n_fail++; $display("FAIL zk_dec_latency got=%0d want=118", lat); end
    n_tests++;
    if (pt !== 32'hECEBECEB) begin n_fail++; $display("FAIL zk_dec_value got=%h want=ecebeceb", pt); end
  endtask

  task automatic test_round_trip();
    int rtab [4];
    logic [31:0] btab [4];
    int lat;
    logic [31:0] ct, pt, exp_ct;
    rtab = '{0, 1, 12, 31};
    btab = '{32'h0123_4567, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0000_FFFF};
    for (int m = 0; m < 4; m++) begin
      exp_ct = ref_rc5(KEY_SEQ, rtab[m], btab[m], 1'b1);
      run_op(1'b1, 1'b0, KEY_SEQ, 5'(rtab[m]), btab[m], lat, ct);
      n_tests++;
      if (lat !== exp_lat(rtab[m])) begin
        n_fail++; $display("FAIL rt_enc_latency r=%0d got=%0d want=%0d", rtab[m], lat, exp_lat(rtab[m]));
      end
      n_tests++;
      if (ct !== exp_ct) begin
        n_fail++; $display("FAIL rt_enc_value r=%0d got=%h want=%h", rtab[m], ct, exp_ct);
      end
      run_op(1'b0, 1'b1, KEY_SEQ, 5'(rtab[m]), ct, lat, pt);
      n_tests++;
      if (lat !== exp_lat(rtab[m])) begin
        n_fail++; $display("FAIL rt_dec_latency r=%0d got=%0d want=%0d", rtab[m], lat, exp_lat(rtab[m]));
      end
      n_tests++;
      if (pt !== btab[m]) begin
        n_fail++; $display("FAIL rt_dec_value r=%0d got=%h want=%h", rtab[m], pt, btab[m]);
      end
    end
  endtask

  task automatic test_both_high();
    int lat;
    logic [31:0] res, exp_ct;
    exp_ct = ref_rc5(KEY_SEQ, 12, 32'h2468_ACE0, 1'b1);
    run_op(1'b1, 1'b1, KEY_SEQ, 5'd12, 32'h2468_ACE0, lat, res);
    n_tests++;
    if (res !== exp_ct) begin n_fail++; $display("FAIL both_high_value got=%h want=%h", res, exp_ct); end
    n_tests++;
    if (lat !== 118) begin n_fail++; $display("FAIL both_high_latency got=%0d want=118", lat); end
  endtask

  task automatic test_busy_ignored();
    int lat, pulses;
    logic [31:0] res, exp_ct;
    exp_ct = ref_rc5(KEY_SEQ, 12, 32'h1357_9BDF, 1'b1);
    encrypt = 1'b1; decrypt = 1'b0; key = KEY_SEQ; num_rounds = 5'd12; d_in = 32'h1357_9BDF;
    @(posedge clk); #1;
    encrypt = 1'b0;
    lat = -1; res = 32'h0; pulses = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = n; res = d_out; end
      end
      if (n == 5)   begin decrypt = 1'b1; d_in = 32'hFFFF_FFFF; key = ~KEY_SEQ; num_rounds = 5'd3; end
      if (n == 6)   decrypt = 1'b0;
      if (n == 60)  begin d_in = 32'h0; key = 128'h0; end
      if (n == 110) encrypt = 1'b1;
      if (n == 111) encrypt = 1'b0;
    end
    n_tests++;
    if (lat !== 118) begin n_fail++; $display("FAIL busy_latency got=%0d want=118", lat); end
    n_tests++;
    if (res !== exp_ct) begin n_fail++; $display("FAIL busy_value got=%h want=%h", res, exp_ct); end
    n_tests++;
    if (pulses !== 1) begin n_fail++; $display("FAIL busy_done_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    logic [31:0] res, exp_ct;
    exp_ct = ref_rc5(KEY_SEQ, 12, 32'hCAFE_F00D, 1'b1);
    encrypt = 1'b1; decrypt = 1'b0; key = KEY_SEQ; num_rounds = 5'd12; d_in = 32'h0BAD_C0DE;
    @(posedge clk); #1;
    encrypt = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (seen || done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done got seen=%b done=%b want 0/0", seen, done);
    end
    n_tests++;
    if (d_out !== 32'h0) begin n_fail++; $display("FAIL midrst_dout got=%h want=00000000", d_out); end
    rst = 1'b0;
    run_op(1'b1, 1'b0, KEY_SEQ, 5'd12, 32'hCAFE_F00D, lat, res);
    n_tests++;
    if (lat !== 118) begin n_fail++; $display("FAIL midrst_restart_latency got=%0d want=118", lat); end
    n_tests++;
    if (res !== exp_ct) begin n_fail++; $display("FAIL midrst_restart_value got=%h want=%h", res, exp_ct); end
  endtask

  task automatic test_done_hold();
    int lat;
    bit held;
    logic [31:0] res, exp_ct;
    exp_ct = ref_rc5(128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 5, 32'h8000_0001, 1'b1);
    run_op(1'b1, 1'b0, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 5'd5, 32'h8000_0001, lat, res);
    n_tests++;
    if (res !== exp_ct) begin n_fail++; $display("FAIL hold_value got=%h want=%h", res, exp_ct); end
    n_tests++;
    if (lat !== exp_lat(5)) begin n_fail++; $display("FAIL hold_latency got=%0d want=%0d", lat, exp_lat(5)); end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done_one_cycle got=%b want=0", done); end
    d_in = 32'h7777_7777; key = 128'h0;
    held = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (d_out !== exp_ct || done !== 1'b0) held = 1'b0;
    end
    n_tests++;
    if (!held) begin n_fail++; $display("FAIL hold_dout got=%h want=%h", d_out, exp_ct); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; encrypt = 1'b0; decrypt = 1'b0;
    num_rounds = 5'd0; key = 128'h0; d_in = 32'h0;
    test_reset();
    test_zero_key();
    test_round_trip();
    test_both_high();
    test_busy_ignored();
    test_reset_mid();
    test_done_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rc5_algo.md
RC5_ALGO -- requirements
Module: rc5_algo

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst, with no other clock or reset.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 encrypt  input  1  one-cycle start pulse for encryption of d_in.
REQ-005 decrypt  input  1  one-cycle start pulse for decryption of d_in.
REQ-006 num_rounds  input  5  round count r, 0..31, not zero-indexed; typical value 12.
REQ-007 key  input  128  secret key; byte k = key[8k+7:8k], 16 bytes.
REQ-008 d_in  input  32  plaintext or ciphertext block.
REQ-009 d_out  output  32  result block, held until next start or reset.
REQ-010 done  output  1  one-cycle pulse; d_out is valid in that cycle.

Function
REQ-011 Algorithm: RC5-16/r/16, with word w=16, P=0xB7E1, Q=0x9E37, t=2(r+1), c=8.
REQ-012 Key words: L[i] = key[16i+15:16i] for i=0..7.
REQ-013 Block words: A = d_in[15:0] and B = d_in[31:16]; d_out = {B,A}.
REQ-014 Rotations use the low 4 bits of the amount word; all additions and subtractions are mod 2^16.
REQ-015 Start: in IDLE, a start on encrypt or decrypt latches key, num_rounds, d_in and mode.
  - Encrypt has priority when both are high in the same cycle.
  - Starts are ignored while not in IDLE.
REQ-016 State INIT: t cycles, with S[0]=P and S[i]=S[i-1]+Q, one entry per cycle.
REQ-017 State MIX: 3*max(t,8) cycles, one step per cycle. Each step:
  - A' = S[i] = (S[i]+A'+B') <<< 3
  - B' = L[j] = (L[j]+A'+B') <<< (A'+B')
  - i = (i+1) mod t; j = (j+1) mod 8
  - A', B', i and j start at 0.
REQ-018 State ENC: the first cycle applies whitening (A+=S[0], B+=S[1]). Then r cycles run, one full round each, for k=1..r:
  - A = ((A^B) <<< B) + S[2k]
  - B = ((B^A) <<< A) + S[2k+1], using the new A.
REQ-019 State DEC: r cycles run for k=r..1:
  - B = ((B-S[2k+1]) >>> A) ^ A
  - A = ((A-S[2k]) >>> B) ^ B
  - A final cycle then applies B-=S[1], A-=S[0].
REQ-020 State DONE: d_out <= {B,A} and done=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency: done rises exactly t + 3*max(t,8) + r + 2 cycles after the start edge, for both modes (118 cycles at r=12).
REQ-022 r=0: no rounds; the result is whitening only (t=2, MIX = 24 cycles).
REQ-023 Decrypt(Encrypt(x)) = x for any key and any r when the same key and r are used.
REQ-024 Input changes after the start cycle have no effect on the operation in progress.

Reset
REQ-025 rst has priority over all other inputs:
  - state=IDLE, done=0, d_out=0
  - A, B, i, j, and the S and L arrays are cleared.
REQ-026 rst mid-operation aborts it with no done pulse; a start is accepted on the first cycle after rst deasserts.

Structure
REQ-027 Package rc5_pkg holds:
  - W=16, P16, Q16, MAX_ROUNDS=31, T_MAX=64
  - the state enum {IDLE, INIT, MIX, ENC, DEC, DONE}
  - the rotl/rotr functions.
REQ-028 Sub-module rc5_key_sched holds the S/L arrays and the INIT/MIX sequencing. It exposes a start input, a ready output and an S read port; the top-level FSM and datapath live in rc5_algo.

Verification
REQ-029 key=0, r=12, encrypt 0xECEBECEB; then decrypt the result -> done after 118 cycles each, final d_out=0xECEBECEB, ciphertext differs from plaintext.
REQ-030 key=0x000102...0F, r=0/1/12/31, random blocks -> round-trip equality; done at t+3*max(t,8)+r+2 cycles.
REQ-031 encrypt and decrypt high in the same cycle -> result equals encrypt-only result.
REQ-032 Start pulse while busy, and d_in/key changed mid-op -> ignored; result is unchanged.
REQ-033 rst asserted mid-ENC -> done stays 0, d_out=0; next start completes normally.
REQ-034 done is high for exactly one cycle per accepted start; d_out holds between operations.
